fwd_hazard_unit: RTL and testbench

Parametrised successor to the EX-stage forwarding logic. The block keeps its own shift register of in-flight producer tags: destination register, write-enable and result latency for each stage after EX. From these tags it generates a per-source forwarding select and a load-use stall for the instruction currently in EX. It generalises the fixed 2-source / 2-stage scheme to NUM_SRC read ports and DEPTH tracked stages. It also adds x0 suppression, latency-aware stalling and a stall performance counter.

---
 rtl/fwd_hazard_unit.sv | 116 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select and load-use stall generator.
// Tracks DEPTH in-flight producer tags and resolves NUM_SRC source ports.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), async active-high reset
//   ex_valid_i        real instruction in EX
//   ex_regwrite_i     EX instruction writes a register
//   ex_rd_i           EX destination register
//   ex_lat_i          stage index at which the EX result is forwardable
//   ex_rs_i           packed source addresses, port j at [j*ADDR_W +: ADDR_W]
//   ex_flush_i        EX instruction squashed this cycle
//   fwd_sel_o         packed 3-bit select per port, 0 = regfile, k = stage k
//   stall_o           hold IF/ID/EX, bubble after EX
//   stall_cnt_o       saturating stall-cycle counter
module fwd_hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int ADDR_W  = 5,
    parameter int LAT_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ex_valid_i,
    input  logic                      ex_regwrite_i,
    input  logic [ADDR_W-1:0]         ex_rd_i,
    input  logic [LAT_W-1:0]          ex_lat_i,
    input  logic [NUM_SRC*ADDR_W-1:0] ex_rs_i,
    input  logic                      ex_flush_i,
    output logic [NUM_SRC*3-1:0]      fwd_sel_o,
    output logic                      stall_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    logic              r_vld [1:DEPTH];
    logic [ADDR_W-1:0] r_rd  [1:DEPTH];
    logic [LAT_W-1:0]  r_lat [1:DEPTH];
    logic [CNT_W-1:0]  r_cnt;

    logic [ADDR_W-1:0] w_rs      [NUM_SRC];
    logic              w_hit     [NUM_SRC];
    logic [2:0]        w_win_k   [NUM_SRC];
    logic [LAT_W-1:0]  w_win_lat [NUM_SRC];
    logic [NUM_SRC-1:0] w_req;
    logic [LAT_W-1:0]  w_lat_eff;
    logic              w_load;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_rs
        assign w_rs[g] = ex_rs_i[g*ADDR_W +: ADDR_W];
    end

    // A zero latency is the same as an ALU result.
    assign w_lat_eff = (ex_lat_i == '0) ? LAT_W'(1) : ex_lat_i;

    assign w_load = ex_valid_i & ex_regwrite_i & (ex_rd_i != '0)
                  & ~ex_flush_i & ~stall_o;

    always_comb begin
        fwd_sel_o = '0;
        w_req     = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            w_hit[j]     = 1'b0;
            w_win_k[j]   = '0;
            w_win_lat[j] = '0;
            // Scan oldest to youngest so the youngest match is left standing.
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_vld[k] && (r_rd[k] == w_rs[j]) && (w_rs[j] != '0)) begin
                    w_hit[j]     = 1'b1;
                    w_win_k[j]   = 3'(k);
                    w_win_lat[j] = r_lat[k];
                end
            end
            if (w_hit[j]) begin
                if (int'(w_win_k[j]) >= int'(w_win_lat[j])) begin
                    fwd_sel_o[j*3 +: 3] = w_win_k[j];
                end else begin
                    w_req[j] = 1'b1;
                end
            end
        end
    end

    assign stall_o     = ex_valid_i & (|w_req);
    assign stall_cnt_o = r_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_vld[k] <= 1'b0;
                r_rd[k]  <= '0;
                r_lat[k] <= '0;
            end
            r_cnt <= '0;
        end else begin
            r_vld[1] <= w_load;
            r_rd[1]  <= ex_rd_i;
            r_lat[1] <= w_lat_eff;
            for (int k = 2; k <= DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_rd[k]  <= r_rd[k-1];
                r_lat[k] <= r_lat[k-1];
            end
            if (stall_o && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    a_lat_range: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (ex_valid_i && ex_regwrite_i) |-> (int'(ex_lat_i) <= DEPTH)
    );
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two configurations (2x2 and 3x4 with a short
// counter), a history-based reference model and directed vectors.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       a_valid, a_we, a_flush;
    logic [4:0] a_rd;
    logic [2:0] a_lat;
    logic [9:0] a_rs;
    logic [5:0] a_sel;
    logic       a_stall;
    logic [15:0] a_cnt;

    logic       b_valid, b_we, b_flush;
    logic [4:0] b_rd;
    logic [2:0] b_lat;
    logic [14:0] b_rs;
    logic [8:0] b_sel;
    logic       b_stall;
    logic [3:0] b_cnt;

    int total = 0;
    int bad = 0;

    fwd_hazard_unit #(.NUM_SRC(2), .DEPTH(2), .ADDR_W(5), .LAT_W(3), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(a_valid), .ex_regwrite_i(a_we),
        .ex_rd_i(a_rd), .ex_lat_i(a_lat), .ex_rs_i(a_rs), .ex_flush_i(a_flush),
        .fwd_sel_o(a_sel), .stall_o(a_stall), .stall_cnt_o(a_cnt)
    );

    fwd_hazard_unit #(.NUM_SRC(3), .DEPTH(4), .ADDR_W(5), .LAT_W(3), .CNT_W(4)) u_b (
        .clk_i(clk), .rst_i(rst), .ex_valid_i(b_valid), .ex_regwrite_i(b_we),
        .ex_rd_i(b_rd), .ex_lat_i(b_lat), .ex_rs_i(b_rs), .ex_flush_i(b_flush),
        .fwd_sel_o(b_sel), .stall_o(b_stall), .stall_cnt_o(b_cnt)
    );

    // History of what each past cycle actually committed to the pipe:
    // h[n] is the producer issued n cycles ago (v=0 for a bubble).
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [2:0] lat;
    } rec_t;

    rec_t ha [1:7];
    rec_t hb [1:7];
    int   ma_cnt = 0;
    int   mb_cnt = 0;

    function automatic void mdl(input rec_t h [1:7], input int depth,
                                input int nsrc, input logic [14:0] rs,
                                input bit valid, output logic [8:0] sel,
                                output bit stall);
        bit req;
        int r;
        sel = '0;
        req = 1'b0;
        for (int j = 0; j < nsrc; j++) begin
            r = int'(rs[j*5 +: 5]);
            if (r != 0) begin
                for (int k = 1; k <= depth; k++) begin
                    if (h[k].v && int'(h[k].rd) == r) begin
                        if (k >= int'(h[k].lat)) sel[j*3 +: 3] = 3'(k);
                        else req = 1'b1;
                        break;
                    end
                end
            end
        end
        stall = valid && req;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model state update.
    initial forever begin
        logic [8:0] s;
        bit st;
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int k = 1; k <= 7; k++) begin
                ha[k] = '0;
                hb[k] = '0;
            end
            ma_cnt = 0;
            mb_cnt = 0;
        end else begin
            mdl(ha, 2, 2, {5'b0, a_rs}, a_valid, s, st);
            if (st && ma_cnt < 65535) ma_cnt++;
            for (int k = 7; k >= 2; k--) ha[k] = ha[k-1];
            ha[1].v   = a_valid && a_we && a_rd != 0 && !a_flush && !st;
            ha[1].rd  = a_rd;
            ha[1].lat = (a_lat == 0) ? 3'd1 : a_lat;

            mdl(hb, 4, 3, b_rs, b_valid, s, st);
            if (st && mb_cnt < 15) mb_cnt++;
            for (int k = 7; k >= 2; k--) hb[k] = hb[k-1];
            hb[1].v   = b_valid && b_we && b_rd != 0 && !b_flush && !st;
            hb[1].rd  = b_rd;
            hb[1].lat = (b_lat == 0) ? 3'd1 : b_lat;
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        logic [8:0] s;
        bit st;
        @(negedge clk);
        mdl(ha, 2, 2, {5'b0, a_rs}, a_valid, s, st);
        chk("m_a_sel", 32'(a_sel), 32'(s[5:0]));
        chk("m_a_stall", 32'(a_stall), 32'(st));
        chk("m_a_cnt", 32'(a_cnt), ma_cnt);
        mdl(hb, 4, 3, b_rs, b_valid, s, st);
        chk("m_b_sel", 32'(b_sel), 32'(s));
        chk("m_b_stall", 32'(b_stall), 32'(st));
        chk("m_b_cnt", 32'(b_cnt), mb_cnt);
    end

    task automatic a_drive(input bit v, input bit we, input int rd,
                           input int lat, input int r0, input int r1,
                           input bit fl);
        @(posedge clk);
        #1;
        a_valid = v;
        a_we    = we;
        a_rd    = 5'(rd);
        a_lat   = 3'(lat);
        a_rs    = {5'(r1), 5'(r0)};
        a_flush = fl;
        @(negedge clk);
    endtask

    task automatic b_drive(input bit v, input bit we, input int rd,
                           input int lat, input int r0, input int r1,
                           input int r2);
        @(posedge clk);
        #1;
        b_valid = v;
        b_we    = we;
        b_rd    = 5'(rd);
        b_lat   = 3'(lat);
        b_rs    = {5'(r2), 5'(r1), 5'(r0)};
        b_flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        a_valid = 1; a_we = 1; a_rd = 5; a_lat = 1; a_rs = {5'd5, 5'd5}; a_flush = 0;
        b_valid = 1; b_we = 1; b_rd = 4; b_lat = 3; b_rs = {5'd4, 5'd4, 5'd4}; b_flush = 0;

        @(negedge clk);
        chk("rst_a_sel", 32'(a_sel), 0);
        chk("rst_a_stall", 32'(a_stall), 0);
        chk("rst_a_cnt", 32'(a_cnt), 0);
        chk("rst_b_sel", 32'(b_sel), 0);
        #2 rst = 1'b0;
        #1;
        chk("rel_a_sel", 32'(a_sel), 0);
        chk("rel_a_stall", 32'(a_stall), 0);
        a_valid = 0; a_we = 0; a_lat = 0;
        b_valid = 0; b_we = 0; b_lat = 0;

        // ALU chain
        a_drive(1, 1, 5, 1, 0, 0, 0);
        chk("alu_issue_stall", 32'(a_stall), 0);
        a_drive(1, 0, 0, 0, 5, 6, 0);
        chk("alu_sel_k1", 32'(a_sel), 6'b000_001);
        chk("alu_no_stall", 32'(a_stall), 0);
        a_drive(1, 0, 0, 0, 5, 6, 0);
        chk("alu_sel_k2", 32'(a_sel), 6'b000_010);

        // Load-use
        a_drive(1, 1, 7, 2, 0, 0, 0);
        a_drive(1, 0, 0, 0, 7, 7, 0);
        chk("lu_stall", 32'(a_stall), 1);
        chk("lu_sel_hold", 32'(a_sel), 0);
        a_drive(1, 0, 0, 0, 7, 7, 0);
        chk("lu_sel_k2", 32'(a_sel), 6'b010_010);
        chk("lu_unstall", 32'(a_stall), 0);
        chk("lu_cnt", 32'(a_cnt), 1);

        // Priority
        a_drive(1, 1, 3, 1, 0, 0, 0);
        a_drive(1, 1, 3, 1, 0, 0, 0);
        a_drive(1, 0, 0, 0, 3, 0, 0);
        chk("prio_youngest", 32'(a_sel), 6'b000_001);

        // x0
        a_drive(1, 1, 0, 2, 0, 0, 0);
        a_drive(1, 0, 0, 0, 0, 0, 0);
        chk("x0_sel", 32'(a_sel), 0);
        chk("x0_stall", 32'(a_stall), 0);

        // Flushed producer, non-writing producer
        a_drive(1, 1, 9, 1, 0, 0, 1);
        a_drive(1, 0, 0, 0, 9, 9, 0);
        chk("flush_sel", 32'(a_sel), 0);
        a_drive(1, 0, 10, 1, 0, 0, 0);
        a_drive(1, 0, 0, 0, 10, 10, 0);
        chk("nowe_sel", 32'(a_sel), 0);

        // Flush during a stall
        a_drive(1, 1, 11, 2, 0, 0, 0);
        a_drive(1, 0, 0, 0, 11, 11, 1);
        chk("flush_stall", 32'(a_stall), 1);
        a_drive(1, 0, 0, 0, 11, 11, 0);
        chk("flush_stall_sel", 32'(a_sel), 6'b010_010);
        chk("flush_stall_cnt", 32'(a_cnt), 2);

        // Zero latency behaves as 1
        a_drive(1, 1, 12, 0, 0, 0, 0);
        a_drive(1, 0, 0, 0, 12, 0, 0);
        chk("lat0_sel", 32'(a_sel), 6'b000_001);
        chk("lat0_stall", 32'(a_stall), 0);

        // Invalid EX never stalls; producer beyond DEPTH is invisible
        a_drive(1, 1, 13, 2, 0, 0, 0);
        a_drive(0, 0, 0, 0, 13, 13, 0);
        chk("inv_stall", 32'(a_stall), 0);
        a_drive(1, 0, 0, 0, 13, 0, 0);
        chk("deep_k2", 32'(a_sel), 6'b000_010);
        a_drive(1, 0, 0, 0, 13, 0, 0);
        chk("beyond_depth", 32'(a_sel), 0);

        // Wide config: lat=3 load, 2-cycle stall
        b_drive(1, 1, 4, 3, 0, 0, 0);
        b_drive(1, 0, 0, 0, 4, 2, 4);
        chk("b_stall1", 32'(b_stall), 1);
        b_drive(1, 0, 0, 0, 4, 2, 4);
        chk("b_stall2", 32'(b_stall), 1);
        b_drive(1, 0, 0, 0, 4, 2, 4);
        chk("b_sel_k3", 32'(b_sel), 9'b011_000_011);
        chk("b_unstall", 32'(b_stall), 0);
        chk("b_cnt2", 32'(b_cnt), 2);

        // Saturate the 4-bit counter: 11 more pairs, 22 more stall cycles
        for (int i = 0; i < 11; i++) begin
            b_drive(1, 1, 4, 3, 0, 0, 0);
            n = 0;
            do begin
                b_drive(1, 0, 0, 0, 4, 2, 4);
                n++;
            end while (b_stall && n < 6);
            chk("b_pair_len", n, 3);
        end
        chk("b_cnt_sat", 32'(b_cnt), 4'hF);
        b_drive(0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a stall
        a_drive(1, 1, 7, 2, 0, 0, 0);
        a_drive(1, 0, 0, 0, 7, 7, 0);
        chk("mid_pre_stall", 32'(a_stall), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_stall_drop", 32'(a_stall), 0);
        chk("mid_sel", 32'(a_sel), 0);
        chk("mid_a_cnt", 32'(a_cnt), 0);
        chk("mid_b_cnt", 32'(b_cnt), 0);
        a_valid = 0; a_we = 0;
        #1 rst = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
